// File: rtl/hz_pkg.sv
// Shared types for the hazard unit: pipeline stage record, FSM state and
// the producer test used by every operand comparator.
package hz_pkg;

  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             load;
  } stage_rec_t;

  typedef enum logic {
    RUN,
    LU_STALL
  } hz_state_e;

  // x0 is hard-wired zero, so a record writing it never produces a value.
  function automatic logic produces(input stage_rec_t rec, input logic [REG_W-1:0] rs);
    return rec.valid && rec.reg_write && (rec.rd != '0) && (rec.rd == rs);
  endfunction

endpackage

// File: rtl/hz_src_cmp.sv
// One decode source operand compared against the EX and MEM records:
// produces the three forward selects (EX wins over MEM) and a load-use flag.
module hz_src_cmp
  import hz_pkg::*;
(
  input  logic [REG_W-1:0] rs_i,
  input  logic             en_i,
  input  stage_rec_t       ex_i,
  input  stage_rec_t       mem_i,
  output logic             frwd_alu_o,
  output logic             frwd_mem_alu_o,
  output logic             frwd_mem_o,
  output logic             load_use_o
);

  logic ex_hit;
  logic mem_hit;

  always_comb begin
    ex_hit         = en_i && produces(ex_i, rs_i);
    mem_hit        = en_i && produces(mem_i, rs_i);
    frwd_alu_o     = ex_hit && !ex_i.load;
    load_use_o     = ex_hit && ex_i.load;
    frwd_mem_alu_o = !ex_hit && mem_hit && !mem_i.load;
    frwd_mem_o     = !ex_hit && mem_hit && mem_i.load;
  end

endmodule

// File: rtl/hazard.sv
// Pipeline hazard unit: operand forwarding selects, one-cycle load-use stall,
// flush bubbles, memory-wait freeze and a load-use stall counter.
module hazard
  import hz_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [REG_W-1:0] i_id_rd,
  input  logic             i_id_reg_write,
  input  logic             i_id_mem_read,
  input  logic             i_flush,
  input  logic             i_mem_wait,
  output logic             o_frwd_alu_op1,
  output logic             o_frwd_mem_alu_op1,
  output logic             o_frwd_mem_op1,
  output logic             o_frwd_alu_op2,
  output logic             o_frwd_mem_alu_op2,
  output logic             o_frwd_mem_op2,
  output logic             o_stall,
  output logic             o_bubble,
  output logic [31:0]      o_stall_cnt
);

  stage_rec_t ex_q, ex_d;
  stage_rec_t mem_q, mem_d;
  hz_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        post_rst_q;

  logic f1_alu, f1_mem_alu, f1_mem, lu1;
  logic f2_alu, f2_mem_alu, f2_mem, lu2;
  logic quiet, freeze, load_use, fwd_ok, stall, bubble;
  stage_rec_t dec;

  hz_src_cmp u_cmp_op1 (
    .rs_i           (i_id_rs1),
    .en_i           (i_id_valid && i_id_use_rs1),
    .ex_i           (ex_q),
    .mem_i          (mem_q),
    .frwd_alu_o     (f1_alu),
    .frwd_mem_alu_o (f1_mem_alu),
    .frwd_mem_o     (f1_mem),
    .load_use_o     (lu1)
  );

  hz_src_cmp u_cmp_op2 (
    .rs_i           (i_id_rs2),
    .en_i           (i_id_valid && i_id_use_rs2),
    .ex_i           (ex_q),
    .mem_i          (mem_q),
    .frwd_alu_o     (f2_alu),
    .frwd_mem_alu_o (f2_mem_alu),
    .frwd_mem_o     (f2_mem),
    .load_use_o     (lu2)
  );

  always_comb begin
    // Outputs stay quiet while reset is held and for one cycle afterwards.
    quiet    = i_rst || post_rst_q;
    freeze   = !quiet && i_mem_wait;
    load_use = !quiet && (lu1 || lu2) && (state_q == RUN);
    fwd_ok   = !quiet && !load_use;

    stall  = 1'b0;
    bubble = 1'b0;
    if (freeze) begin
      stall = 1'b1;
    end else if (!quiet && i_flush) begin
      bubble = 1'b1;
    end else if (load_use) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end

    dec = '{valid: i_id_valid, rd: i_id_rd, reg_write: i_id_reg_write, load: i_id_mem_read};

    ex_d    = ex_q;
    mem_d   = mem_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      mem_d = ex_q;
      ex_d  = bubble ? stage_rec_t'('0) : dec;
      if (!quiet && i_flush) begin
        state_d = RUN;
      end else if (load_use) begin
        state_d = LU_STALL;
        cnt_d   = cnt_q + 32'd1;
      end else begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_q       <= '0;
      mem_q      <= '0;
      state_q    <= RUN;
      cnt_q      <= '0;
      post_rst_q <= 1'b1;
    end else begin
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      post_rst_q <= 1'b0;
    end
  end

  assign o_frwd_alu_op1     = fwd_ok && f1_alu;
  assign o_frwd_mem_alu_op1 = fwd_ok && f1_mem_alu;
  assign o_frwd_mem_op1     = fwd_ok && f1_mem;
  assign o_frwd_alu_op2     = fwd_ok && f2_alu;
  assign o_frwd_mem_alu_op2 = fwd_ok && f2_mem_alu;
  assign o_frwd_mem_op2     = fwd_ok && f2_mem;
  assign o_stall            = stall;
  assign o_bubble           = bubble;
  assign o_stall_cnt        = cnt_q;

endmodule

// File: tb/tb_hazard.sv
// Directed scoreboard bench for the hazard unit: stimulus pushes expected
// output vectors, a negedge monitor pops and compares them.
module tb_hazard;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  rs1, rs2, rd;
  logic        use1, use2, rw, ld;
  logic        flush, mwait;
  logic        fa1, fma1, fm1, fa2, fma2, fm2, stall, bubble;
  logic [31:0] cnt;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [39:0] exp_q[$];
  string       name_q[$];

  hazard dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_id_valid         (id_valid),
    .i_id_rs1           (rs1),
    .i_id_rs2           (rs2),
    .i_id_use_rs1       (use1),
    .i_id_use_rs2       (use2),
    .i_id_rd            (rd),
    .i_id_reg_write     (rw),
    .i_id_mem_read      (ld),
    .i_flush            (flush),
    .i_mem_wait         (mwait),
    .o_frwd_alu_op1     (fa1),
    .o_frwd_mem_alu_op1 (fma1),
    .o_frwd_mem_op1     (fm1),
    .o_frwd_alu_op2     (fa2),
    .o_frwd_mem_alu_op2 (fma2),
    .o_frwd_mem_op2     (fm2),
    .o_stall            (stall),
    .o_bubble           (bubble),
    .o_stall_cnt        (cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Vector layout: {fa1,fma1,fm1,fa2,fma2,fm2,stall,bubble,cnt[31:0]}
  function automatic logic [39:0] mk(input logic [7:0] flags, input logic [31:0] c);
    return {flags, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [4:0] a, input logic ua,
                     input logic [4:0] b, input logic ub,
                     input logic [4:0] d, input logic w, input logic l);
    id_valid = v; rs1 = a; use1 = ua; rs2 = b; use2 = ub; rd = d; rw = w; ld = l;
  endtask

  task automatic expect_vec(input string nm, input logic [39:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are combinational on inputs set #1 after posedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [39:0] e, a;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {fa1, fma1, fm1, fa2, fma2, fm2, stall, bubble, cnt};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", nm, a, e);
      end
    end
  end

  initial begin
    int unsigned guard;
    rst = 1'b1; flush = 1'b1; mwait = 1'b1;
    dec(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1);

    // Reset held: every control output gated even with flush/wait asserted.
    step(); expect_vec("rst_hold1", mk(8'b0000_0000, 32'd0));
    step(); expect_vec("rst_hold2", mk(8'b0000_0000, 32'd0));
    // Cycle after reset: still quiet.
    step(); rst = 1'b0; mwait = 1'b0; flush = 1'b1;
    dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    expect_vec("post_rst", mk(8'b0000_0000, 32'd0));

    // add x5 in EX, decode reads rs1=x5 (rs2=x5 but unused).
    step(); flush = 1'b0; dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    expect_vec("add_x5_issue", mk(8'b0000_0000, 32'd0));
    step(); dec(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    expect_vec("ex_fwd_op1", mk(8'b1000_0000, 32'd0));
    step(); dec(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    expect_vec("mem_alu_fwd_op2", mk(8'b0000_1000, 32'd0));

    // lw x6 then rs2=x6: one stall+bubble, then MEM load forward.
    step(); dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    expect_vec("lw_x6_issue", mk(8'b0000_0000, 32'd0));
    step(); dec(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0);
    expect_vec("load_use_stall", mk(8'b0000_0011, 32'd0));
    step();
    expect_vec("load_use_resolve", mk(8'b0000_0100, 32'd1));

    // x7 written by both EX and MEM: EX wins on both operands.
    step(); dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    expect_vec("x7_first", mk(8'b0000_0000, 32'd1));
    step();
    expect_vec("x7_second", mk(8'b0000_0000, 32'd1));
    step(); dec(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
    expect_vec("ex_priority", mk(8'b1001_0000, 32'd1));

    // Load to x0 in EX, decode reads x0: nothing.
    step(); dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    expect_vec("x0_issue", mk(8'b0000_0000, 32'd1));
    step(); dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    expect_vec("x0_no_fwd", mk(8'b0000_0000, 32'd1));

    // Load-use hazard coinciding with flush.
    step(); dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1);
    expect_vec("lw_x10_issue", mk(8'b0000_0000, 32'd1));
    step(); flush = 1'b1; dec(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    expect_vec("flush_beats_lu", mk(8'b0000_0001, 32'd1));
    step(); flush = 1'b0; dec(1'b0, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    expect_vec("after_flush_cnt", mk(8'b0000_0000, 32'd1));

    // Memory wait mid-hazard for 3 cycles, then reset.
    step(); dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1);
    expect_vec("lw_x11_issue", mk(8'b0000_0000, 32'd1));
    step(); mwait = 1'b1; dec(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    expect_vec("wait1", mk(8'b0000_0010, 32'd1));
    step(); expect_vec("wait2", mk(8'b0000_0010, 32'd1));
    step(); expect_vec("wait3", mk(8'b0000_0010, 32'd1));
    step(); mwait = 1'b0; rst = 1'b1;
    expect_vec("mid_rst", mk(8'b0000_0000, 32'd1));
    step(); rst = 1'b0;
    expect_vec("rst_clears", mk(8'b0000_0000, 32'd0));
    step(); expect_vec("no_stale_stall", mk(8'b0000_0000, 32'd0));

    step(); step();
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      step();
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard.md
HAZARD -- requirements
Module: hazard

Interface
REQ-001 SHALL provide i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL provide i_rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL provide i_id_valid, input, 1, decode stage holds a real instruction.
REQ-004 SHALL provide i_id_rs1 and i_id_rs2, input, 5 each, decode source register indices.
REQ-005 SHALL provide i_id_use_rs1 and i_id_use_rs2, input, 1 each, decode instruction reads that source.
REQ-006 SHALL provide i_id_rd, input, 5, decode destination index.
REQ-007 SHALL provide i_id_reg_write, input, 1, decode instruction writes rd.
REQ-008 SHALL provide i_id_mem_read, input, 1, decode instruction is a load.
REQ-009 SHALL provide i_flush, input, 1, taken branch/jump resolved; kill decode instruction.
REQ-010 SHALL provide i_mem_wait, input, 1, data memory not ready; freeze whole pipeline.
REQ-011 SHALL provide o_frwd_alu_op1, o_frwd_mem_alu_op1, o_frwd_mem_op1, output, 1 each, op1 forward selects for the decode-stage operand mux.
REQ-012 SHALL provide o_frwd_alu_op2, o_frwd_mem_alu_op2, o_frwd_mem_op2, output, 1 each, op2 forward selects.
REQ-013 SHALL provide o_stall, output, 1, hold PC and IF/ID register this cycle.
REQ-014 SHALL provide o_bubble, output, 1, load NOP into ID/EX register this cycle.
REQ-015 SHALL provide o_stall_cnt, output, 32, count of load-use stall cycles since reset.

Function
REQ-016 SHALL keep two registered records, EX and MEM, each {valid, rd, reg_write, load}.
REQ-017 SHALL, when not frozen, shift MEM <= EX and EX <= decode info, or EX <= invalid when o_bubble=1.
REQ-018 SHALL, while i_mem_wait=1, hold both records, o_stall_cnt and FSM state; o_stall=1, o_bubble=0.
REQ-019 SHALL treat a record as a producer only if valid=1, reg_write=1 and rd!=0; x0 is never forwarded or stalled on.
REQ-020 SHALL, per source with use=1 and i_id_valid=1, assert o_frwd_alu_opN when EX produces rs and EX.load=0.
REQ-021 SHALL otherwise assert o_frwd_mem_alu_opN when MEM produces rs and MEM.load=0, or o_frwd_mem_opN when MEM produces rs and MEM.load=1.
REQ-022 SHALL give EX priority over MEM, so at most one select per operand is high.
REQ-023 SHALL, when EX produces rs with EX.load=1 (load-use), assert o_stall=1 and o_bubble=1 for exactly one cycle, with all forward selects 0; the next cycle resolves by o_frwd_mem_opN.
REQ-024 SHALL implement FSM RUN -> LU_STALL on load-use hazard, LU_STALL -> RUN next unfrozen cycle; a second stall cycle is never inserted for the same hazard.
REQ-025 SHALL, on i_flush=1, force o_bubble=1 and drive o_stall=0; flush beats load-use, FSM returns to RUN.
REQ-026 SHALL increment o_stall_cnt once per load-use stall cycle, wrapping 0xFFFFFFFF -> 0.
REQ-027 SHALL leave write-back distance to the register file's write-before-read; no WB forwarding.

Reset
REQ-028 SHALL, on i_rst=1, clear both records to invalid, FSM to RUN, o_stall_cnt to 0.
REQ-029 SHALL drive all forward selects, o_stall and o_bubble to 0 during reset and in the cycle after.
REQ-030 SHALL discard any in-progress stall or freeze when reset is asserted mid-operation.

Structure
REQ-031 SHALL place the record struct, FSM state enum and register-index width constant in shared package hz_pkg.
REQ-032 SHALL use one sub-module hz_src_cmp (one source vs EX/MEM records -> three selects plus hazard flag), instantiated per operand.

Verification
REQ-033 SHALL cover: add x5 in EX, decode reads rs1=x5 -> o_frwd_alu_op1=1, o_stall=0.
REQ-034 SHALL cover: lw x6 in EX, decode reads rs2=x6 -> one cycle o_stall=o_bubble=1, then o_frwd_mem_op2=1, o_stall_cnt=1.
REQ-035 SHALL cover: x7 written by both EX and MEM, decode reads x7 on both -> only o_frwd_alu_op1/op2=1.
REQ-036 SHALL cover: producer rd=x0 in EX, decode reads x0 -> all selects 0, no stall.
REQ-037 SHALL cover: load-use hazard with i_flush=1 same cycle -> o_bubble=1, o_stall=0, o_stall_cnt unchanged.
REQ-038 SHALL cover: i_mem_wait=1 for 3 cycles mid-hazard, then i_rst=1 -> records hold during wait; after reset all outputs 0, count 0.
